uart_cmd_assembler: RTL and testbench

//  Sits between the UART receiver/transmitter and the command processor inside DSO_dig.

---
 rtl/dso_cmd_pkg.sv | 20 ++
 rtl/uart_cmd_assembler_if.sv | 28 ++
 rtl/uart_resp_tx.sv | 53 +++++
 rtl/uart_cmd_assembler.sv | 98 +++++++++
 tb/tb_uart_cmd_assembler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dso_cmd_pkg.sv
// Shared definitions for the DSO host command link: opcodes, ack codes and FSM state types.
package dso_cmd_pkg;

  localparam logic [7:0] DUMP_CH  = 8'h01;
  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] TRIG_LVL = 8'h03;
  localparam logic [7:0] TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC  = 8'h05;
  localparam logic [7:0] TRIG_CFG = 8'h06;
  localparam logic [7:0] TRIG_RD  = 8'h07;
  localparam logic [7:0] EEP_WRT  = 8'h08;
  localparam logic [7:0] EEP_RD   = 8'h09;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

  typedef enum logic [1:0] {IDLE, B2, B3, VALID} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Signal bundle between the UART rx/tx, the command processor and the command assembler.
interface uart_cmd_assembler_if;

  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_clr_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    output rx_clr_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent, frame_err
  );

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    input  rx_clr_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent, frame_err
  );

endinterface

// File: rtl/uart_resp_tx.sv
// Single-byte response launcher: latches the byte, pulses trmt once, reports completion.
module uart_resp_tx
  import dso_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp_data_i,
  input  logic       send_resp_i,
  input  logic       tx_done_i,
  output logic [7:0] tx_data_o,
  output logic       trmt_o,
  output logic       resp_sent_o
);

  tx_state_t  state_q;
  logic [7:0] tx_data_q;
  logic       trmt_q;
  logic       resp_sent_q;

  // No queue: a request arriving while busy is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (send_resp_i) begin
            tx_data_q <= resp_data_i;
            trmt_q    <= 1'b1;
            state_q   <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done_i) begin
            resp_sent_q <= 1'b1;
            state_q     <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_data_o   = tx_data_q;
  assign trmt_o      = trmt_q;
  assign resp_sent_o = resp_sent_q;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles 3-byte host commands into a 24-bit word with inter-byte timeout resync,
// and forwards single-byte responses to the UART transmitter.
module uart_cmd_assembler
  import dso_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_assembler_if.slave  bus_io
);

  rx_state_t       state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [23:0]     cmd_q;
  logic            cmd_rdy_q;
  logic            frame_err_q;

  logic in_frame;
  logic expire;
  logic accept;

  assign in_frame = (state_q == B2) || (state_q == B3);
  assign expire   = in_frame && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  // Timeout beats a simultaneous byte; the byte stays pending and starts the next frame.
  assign accept   = bus_io.rx_rdy && (state_q != VALID) && !expire && !rst;

  assign bus_io.rx_clr_rdy = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (accept || !in_frame) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (expire) begin
        state_q     <= IDLE;
        to_cnt_q    <= '0;
        frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              cmd_q[23:16] <= bus_io.rx_data;
              state_q      <= B2;
            end
          end
          B2: begin
            if (accept) begin
              cmd_q[15:8] <= bus_io.rx_data;
              state_q     <= B3;
            end
          end
          B3: begin
            if (accept) begin
              cmd_q[7:0] <= bus_io.rx_data;
              cmd_rdy_q  <= 1'b1;
              state_q    <= VALID;
            end
          end
          VALID: begin
            if (bus_io.clr_cmd_rdy) begin
              cmd_rdy_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus_io.cmd       = cmd_q;
  assign bus_io.cmd_rdy   = cmd_rdy_q;
  assign bus_io.frame_err = frame_err_q;

  uart_resp_tx u_resp_tx (
    .clk         (clk),
    .rst         (rst),
    .resp_data_i (bus_io.resp_data),
    .send_resp_i (bus_io.send_resp),
    .tx_done_i   (bus_io.tx_done),
    .tx_data_o   (bus_io.tx_data),
    .trmt_o      (bus_io.trmt),
    .resp_sent_o (bus_io.resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios plus randomized traffic against a
// transaction-level model (byte count, last-accept timestamp, response in flight).
module tb_uart_cmd_assembler;

  localparam int unsigned TC = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_assembler_if bus ();

  uart_cmd_assembler #(
    .TIMEOUT_CYC (TC),
    .TO_W        (6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: frame = number of bytes collected so far plus time of the last accept.
  bit          chk_en = 1'b0;
  int unsigned cyc    = 0;
  int unsigned m_n    = 0;
  int unsigned m_last = 0;
  logic [23:0] m_cmd  = '0;
  bit          m_held = 1'b0;
  bit          m_ferr = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_trmt = 1'b0;
  bit          m_rs   = 1'b0;
  logic [7:0]  m_txd  = '0;
  bit          acc_last = 1'b0;

  always @(negedge clk) begin
    bit exp_acc;
    bit expire;
    cyc++;
    if (chk_en) begin
      expire  = (m_n != 0) && (cyc - m_last == TC);
      exp_acc = !rst && bus.rx_rdy && !m_held && !expire;
      check("rx_clr_rdy", 32'(bus.rx_clr_rdy), 32'(exp_acc));
      check("cmd",        32'(bus.cmd),        32'(m_cmd));
      check("cmd_rdy",    32'(bus.cmd_rdy),    32'(m_held));
      check("frame_err",  32'(bus.frame_err),  32'(m_ferr));
      check("tx_data",    32'(bus.tx_data),    32'(m_txd));
      check("trmt",       32'(bus.trmt),       32'(m_trmt));
      check("resp_sent",  32'(bus.resp_sent),  32'(m_rs));
      acc_last = exp_acc;
      if (rst) begin
        m_n = 0; m_cmd = '0; m_held = 0; m_ferr = 0;
        m_busy = 0; m_trmt = 0; m_rs = 0; m_txd = '0;
      end else begin
        m_ferr = expire;
        if (expire) begin
          m_n = 0;
        end else if (exp_acc) begin
          m_cmd[8*(2-m_n) +: 8] = bus.rx_data;
          m_last = cyc;
          m_n++;
          if (m_n == 3) begin
            m_n    = 0;
            m_held = 1;
          end
        end else if (m_held && bus.clr_cmd_rdy) begin
          m_held = 0;
        end
        m_trmt = 0;
        m_rs   = 0;
        if (!m_busy && bus.send_resp) begin
          m_txd  = bus.resp_data;
          m_trmt = 1;
          m_busy = 1;
        end else if (m_busy && bus.tx_done) begin
          m_rs   = 1;
          m_busy = 0;
        end
      end
    end else begin
      acc_last = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    do begin
      tick(1);
      k++;
    end while (!acc_last && k < 200);
    bus.rx_rdy = 1'b0;
    if (!acc_last) begin
      n_tot++;
      $display("FAIL send_byte %h: not accepted within %0d cycles", b, k);
    end
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    tick(1);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int unsigned rate;
    bus.rx_data = '0; bus.rx_rdy = 0; bus.clr_cmd_rdy = 0;
    bus.resp_data = '0; bus.send_resp = 0; bus.tx_done = 0;
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    rst = 1'b0;
    check("reset cmd", 32'(bus.cmd), 32'h0);
    check("reset cmd_rdy", 32'(bus.cmd_rdy), 32'h0);

    // 1: basic frame
    send_byte(8'h02); send_byte(8'h1C); send_byte(8'h00);
    check("t1 cmd", 32'(bus.cmd), 32'h021C00);
    check("t1 cmd_rdy", 32'(bus.cmd_rdy), 32'h1);
    tick(3);
    check("t1 cmd_rdy held", 32'(bus.cmd_rdy), 32'h1);
    pulse_clr();
    check("t1 cmd_rdy cleared", 32'(bus.cmd_rdy), 32'h0);
    check("t1 cmd kept", 32'(bus.cmd), 32'h021C00);

    // 2: timeout after one byte
    send_byte(8'h03);
    tick(TC);
    check("t2 frame_err", 32'(bus.frame_err), 32'h1);
    check("t2 cmd partial", 32'(bus.cmd), 32'h031C00);
    tick(1);
    check("t2 frame_err pulse", 32'(bus.frame_err), 32'h0);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h80);
    check("t2 cmd", 32'(bus.cmd), 32'h040080);

    // 3: byte pending while VALID, then clear
    bus.rx_data = 8'h05; bus.rx_rdy = 1'b1;
    tick(2);
    check("t3 held off", 32'(bus.rx_clr_rdy), 32'h0);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    check("t3 clear wins", 32'(bus.rx_clr_rdy), 32'h0);
    tick(1);
    bus.clr_cmd_rdy = 1'b0;
    check("t3 accepted next", 32'(bus.rx_clr_rdy), 32'h1);
    tick(1);
    bus.rx_rdy = 1'b0;
    send_byte(8'h00); send_byte(8'h0F);
    check("t3 cmd", 32'(bus.cmd), 32'h05000F);
    pulse_clr();

    // 4: response path
    bus.resp_data = 8'hA5; bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    check("t4 tx_data", 32'(bus.tx_data), 32'hA5);
    check("t4 trmt", 32'(bus.trmt), 32'h1);
    tick(1);
    check("t4 trmt pulse", 32'(bus.trmt), 32'h0);
    bus.resp_data = 8'h99; bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    check("t4 busy ignore", 32'(bus.tx_data), 32'hA5);
    check("t4 busy no trmt", 32'(bus.trmt), 32'h0);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    check("t4 resp_sent", 32'(bus.resp_sent), 32'h1);
    tick(1);
    check("t4 resp_sent pulse", 32'(bus.resp_sent), 32'h0);

    // 5: reset mid-frame
    send_byte(8'h09); send_byte(8'h2A);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5 cmd", 32'(bus.cmd), 32'h0);
    check("t5 tx_data", 32'(bus.tx_data), 32'h0);
    check("t5 cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    send_byte(8'h09); send_byte(8'h2A); send_byte(8'h00);
    check("t5 cmd after", 32'(bus.cmd), 32'h092A00);

    // 6: clear + new byte + response request on one cycle
    pulse_clr();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    bus.rx_data = 8'h04; bus.rx_rdy = 1'b1; bus.clr_cmd_rdy = 1'b1;
    bus.resp_data = 8'h5A; bus.send_resp = 1'b1;
    #1;
    check("t6 clear wins", 32'(bus.rx_clr_rdy), 32'h0);
    tick(1);
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    check("t6 cmd_rdy fell", 32'(bus.cmd_rdy), 32'h0);
    check("t6 accepted", 32'(bus.rx_clr_rdy), 32'h1);
    check("t6 trmt", 32'(bus.trmt), 32'h1);
    check("t6 tx_data", 32'(bus.tx_data), 32'h5A);
    tick(1);
    bus.rx_rdy = 1'b0;
    send_byte(8'h05); send_byte(8'h06);
    check("t6 cmd", 32'(bus.cmd), 32'h040506);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    check("t6 resp_sent", 32'(bus.resp_sent), 32'h1);
    pulse_clr();

    // Random traffic: alternate busy and sparse phases so timeouts occur.
    for (int c = 0; c < 4000; c++) begin
      rate = ((c / 300) % 2 == 1) ? 3 : 40;
      if (bus.rx_rdy && acc_last) bus.rx_rdy = 1'b0;
      if (!bus.rx_rdy && $urandom_range(99) < rate) begin
        bus.rx_data = 8'($urandom);
        bus.rx_rdy  = 1'b1;
      end
      bus.clr_cmd_rdy = ($urandom_range(7) == 0);
      bus.send_resp   = ($urandom_range(9) == 0);
      bus.resp_data   = 8'($urandom);
      bus.tx_done     = ($urandom_range(5) == 0);
      rst             = ($urandom_range(599) == 0);
      tick(1);
    end
    bus.rx_rdy = 0; bus.clr_cmd_rdy = 0; bus.send_resp = 0; bus.tx_done = 0; rst = 0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
